// File: rtl/pwm_width_capture_if.sv
// ============================================================================
// Module      : pwm_width_capture_if
// Description : PWM line and measured-width result bundle for pwm_width_capture.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_width_capture_if;
    logic       PW;
    logic [6:0] Q;
    logic       VALID;
    logic       OVF;
    logic       BUSY;

    modport master (output PW, input Q, input VALID, input OVF, input BUSY);
    modport slave  (input PW, output Q, output VALID, output OVF, output BUSY);
endinterface

`default_nettype wire

// File: rtl/pwm_width_capture.sv
// ============================================================================
// Module      : pwm_width_capture
// Description : Measures the high-time of each PW pulse in XCK cycles
//               (saturating at 127) and reports it with a one-cycle strobe.
//               Optional macro PWCAP_GLITCH_EN drops pulses below MIN_WIDTH.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_width_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 2
) (
    input  wire                 XCK,
    input  wire                 RESET,
    pwm_width_capture_if.slave  cap
);

`ifdef PWCAP_GLITCH_EN
    localparam bit c_GLITCH_EN = 1'b1;
`else
    localparam bit c_GLITCH_EN = 1'b0;
`endif

    // With the filter off a minimum of 1 never rejects, since CNT starts at 1.
    localparam logic [6:0] c_MIN_EFF = c_GLITCH_EN ? 7'(MIN_WIDTH) : 7'd1;
    localparam logic [6:0] c_MAX     = 7'd127;
    localparam logic [6:0] c_FLUSH   = 7'(SYNC_STAGES);

    typedef enum logic [1:0] {
        S_ARM       = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_MEASURE   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_pwp;
    logic [6:0]               r_cnt;
    logic                     r_sat;
    logic [6:0]               r_q;
    logic                     r_valid;
    logic                     r_ovf;
    logic                     r_busy;

    logic                     w_pws;
    logic                     w_rise;
    logic                     w_fall;
    logic                     w_short;

    assign w_pws   = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_pws & ~r_pwp;
    assign w_fall  = ~w_pws & r_pwp;
    assign w_short = (r_cnt < c_MIN_EFF);

    always_ff @(posedge XCK) begin
        if (RESET) begin
            r_sync  <= '0;
            r_pwp   <= 1'b0;
            r_state <= S_ARM;
            r_cnt   <= 7'd0;
            r_sat   <= 1'b0;
            r_q     <= 7'd0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], cap.PW};
            r_pwp   <= w_pws;
            r_valid <= 1'b0;
            case (r_state)
                // Stay armed until PWS has been low with the synchroniser fully
                // refilled, so a pulse already high at reset release is ignored.
                S_ARM: begin
                    if (w_pws) begin
                        r_cnt <= 7'd0;
                    end else if (r_cnt == c_FLUSH) begin
                        r_cnt   <= 7'd0;
                        r_state <= S_WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_cnt   <= 7'd1;
                        r_sat   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_fall) begin
                        if (!w_short) begin
                            r_q     <= r_cnt;
                            r_ovf   <= r_sat;
                            r_valid <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_WAIT_RISE;
                    end else if (w_pws) begin
                        if (r_cnt != c_MAX) begin
                            r_cnt <= r_cnt + 7'd1;
                        end else begin
                            r_sat <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_ARM;
                end
            endcase
        end
    end

    assign cap.Q     = r_q;
    assign cap.VALID = r_valid;
    assign cap.OVF   = r_ovf;
    assign cap.BUSY  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pwm_width_capture.sv
// ============================================================================
// Module      : tb_pwm_width_capture
// Description : Directed self-checking bench for pwm_width_capture with a
//               pulse-level reference model checked every cycle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_width_capture;

    localparam int SS  = 2;
    localparam int MINW = 3;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_width_capture_if bus();

    pwm_width_capture #(.SYNC_STAGES(SS), .MIN_WIDTH(MINW)) dut (
        .XCK   (clk),
        .RESET (rst),
        .cap   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Pulse-level model: a pulse of n high samples is reported SS edges after
    // its first low sample, if it started after a post-reset low sample.
    typedef struct { int due; int q; bit ovf; } rep_t;
    rep_t        pend[$];
    bit          rep_src [0:MAXE-1];
    int          k        = -1;
    int          rr       = -1;
    bit          started  = 1'b0;
    bit          seen_low = 1'b0;
    int          run      = 0;
    bit          run_rep  = 1'b0;
    int          m_q      = 0;
    bit          m_ovf    = 1'b0;
    bit          e_valid;
    bit          e_busy;
    int          last_hi  = -1;

    // DUT-observed reports and counters, cleared by each scenario
    int          got_q[$];
    int          got_o[$];
    int          got_edge[$];
    int          busy_cnt = 0;

    function automatic bit is_short(input int n);
`ifdef PWCAP_GLITCH_EN
        return n < MINW;
`else
        return n < 1;
`endif
    endfunction

    always @(posedge clk) begin
        k++;
        if (rst) begin
            rr = k; started = 1'b1; seen_low = 1'b0; run = 0; run_rep = 1'b0;
            pend.delete(); m_q = 0; m_ovf = 1'b0; rep_src[k] = 1'b0;
        end else if (bus.PW) begin
            if (run == 0) run_rep = seen_low;
            run++;
            rep_src[k] = run_rep;
            last_hi = k;
        end else begin
            if (run > 0 && run_rep && !is_short(run))
                pend.push_back('{k + SS, (run > 127) ? 127 : run, run > 127});
            run = 0; seen_low = 1'b1; rep_src[k] = 1'b0;
        end
        e_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == k) begin
            e_valid = 1'b1; m_q = pend[0].q; m_ovf = pend[0].ovf;
            void'(pend.pop_front());
        end
        e_busy = (k - SS > rr) && rep_src[k - SS];
        #1;
        if (started) begin
            chk("valid", 32'(bus.VALID), 32'(e_valid));
            chk("busy",  32'(bus.BUSY),  32'(e_busy));
            chk("q",     32'(bus.Q),     32'(m_q));
            chk("ovf",   32'(bus.OVF),   32'(m_ovf));
            if (bus.VALID === 1'b1) begin
                got_q.push_back(int'(bus.Q));
                got_o.push_back(int'(bus.OVF));
                got_edge.push_back(k);
            end
            if (bus.BUSY === 1'b1) busy_cnt++;
        end
    end

    task automatic cyc(input logic pw, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.PW = pw;
            rst    = r;
        end
    endtask

    task automatic clr();
        got_q.delete(); got_o.delete(); got_edge.delete(); busy_cnt = 0;
    endtask

    task automatic expect_reps(input string name, input int eq[$], input int eo[$]);
        chk({name, "_count"}, 32'(got_q.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size(); i++) begin
            chk({name, "_q"},   (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(eq[i]));
            chk({name, "_ovf"}, (i < got_o.size()) ? 32'(got_o[i]) : 32'hFFFF_FFFF, 32'(eo[i]));
        end
    endtask

    initial begin
        bus.PW = 1'b0;
        // Single 40-cycle pulse
        cyc(0, 1, 3);
        cyc(0, 0, 5);
        clr();
        cyc(1, 0, 40);
        cyc(0, 0, 6);
        expect_reps("single40", '{40}, '{0});
        chk("single40_busy_cycles", 32'(busy_cnt), 32'd40);
        chk("single40_latency", (got_edge.size() > 0) ? 32'(got_edge[0] - last_hi) : 32'hFFFF_FFFF, 32'(SS + 1));

        // Width boundaries and non-sticky overflow
        clr();
        cyc(1, 0, 1);   cyc(0, 0, 4);
        cyc(1, 0, 127); cyc(0, 0, 4);
        cyc(1, 0, 200); cyc(0, 0, 4);
        cyc(1, 0, 10);  cyc(0, 0, 6);
        expect_reps("bounds", '{1, 127, 127, 10}, '{0, 0, 1, 0});

        // Pulse already high at reset release is not reported
        cyc(1, 1, 3);
        clr();
        cyc(1, 0, 30); cyc(0, 0, 4);
        cyc(1, 0, 12); cyc(0, 0, 6);
        expect_reps("armed", '{12}, '{0});

        // Back-to-back pulses with a single low cycle between them
        clr();
        cyc(1, 0, 5); cyc(0, 0, 1);
        cyc(1, 0, 6); cyc(0, 0, 6);
        expect_reps("b2b", '{5, 6}, '{0, 0});

        // Reset in the middle of a 50-cycle pulse
        clr();
        cyc(1, 0, 25); cyc(1, 1, 1); cyc(1, 0, 24); cyc(0, 0, 4);
        chk("midrst_q",    32'(bus.Q),    32'd0);
        chk("midrst_ovf",  32'(bus.OVF),  32'd0);
        chk("midrst_busy", 32'(bus.BUSY), 32'd0);
        cyc(1, 0, 20); cyc(0, 0, 6);
        expect_reps("midrst", '{20}, '{0});

        // Short pulses against the glitch filter
        clr();
        cyc(1, 0, 1); cyc(0, 0, 3);
        cyc(1, 0, 2); cyc(0, 0, 3);
        cyc(1, 0, 3); cyc(0, 0, 6);
`ifdef PWCAP_GLITCH_EN
        expect_reps("glitch", '{3}, '{0});
`else
        expect_reps("glitch", '{1, 2, 3}, '{0, 0, 0});
`endif

        // PW stuck high: stays busy, never reports
        clr();
        cyc(1, 0, 300);
        expect_reps("stuck", '{}, '{});
        chk("stuck_busy", 32'(bus.BUSY), 32'd1);
        cyc(1, 1, 2);
        cyc(0, 0, 4);
        chk("stuck_rst_busy", 32'(bus.BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
